// File: rtl/div_inverse_gen.sv
// Reciprocal generator: for divisor d produces shift s = N + ceil(log2 d) and
// inverse m = ceil(2^s / d) so that floor(dividend*m >> s) == dividend / d.
module div_inverse_gen #(
  parameter int unsigned DIVIDEND_WIDTH = 16,
  parameter int unsigned WIDTH_INVERSE  = 17,
  parameter int unsigned WIDTH_SHIFT    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVIDEND_WIDTH-1:0] divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] dividend_out,
  output logic [WIDTH_INVERSE-1:0]  div_inverse,
  output logic [WIDTH_SHIFT-1:0]    div_shift,
  output logic                      div_err
);

  localparam int unsigned N  = DIVIDEND_WIDTH;
  localparam int unsigned RW = N + 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned LW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [N-1:0]   dsr_q, dsr_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [RW-1:0]  quo_q, quo_d;
  logic [LW-1:0]  len_q, len_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic                      in_ready_d, out_valid_d, div_err_d;
  logic [N-1:0]              dividend_out_d;
  logic [WIDTH_INVERSE-1:0]  div_inverse_d;
  logic [WIDTH_SHIFT-1:0]    div_shift_d;

  logic [N-1:0]   dm1;
  logic [LW-1:0]  bitlen;
  logic           ge;
  logic [RW-1:0]  rem_sub;
  logic [RW-1:0]  quo_next;

  // l = bit length of (d-1), i.e. ceil(log2 d)
  always_comb begin
    dm1    = dsr_q - N'(1);
    bitlen = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (dm1[i]) bitlen = LW'(i + 1);
    end
  end

  // One restoring-division step; remainder stays below 2d so N+1 bits suffice
  always_comb begin
    ge       = (rem_q >= RW'(dsr_q));
    rem_sub  = ge ? (rem_q - RW'(dsr_q)) : rem_q;
    quo_next = RW'({quo_q, ge});
  end

  always_comb begin
    state_d        = state_q;
    dvd_d          = dvd_q;
    dsr_d          = dsr_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    out_valid_d    = out_valid;
    dividend_out_d = dividend_out;
    div_inverse_d  = div_inverse;
    div_shift_d    = div_shift;
    div_err_d      = div_err;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          state_d = NORM;
        end
      end
      NORM: begin
        quo_d   = '0;
        state_d = DIV;
        if (dsr_q == '0) begin
          // zero divisor spends a single DIV slot so the flag lands two cycles after accept
          err_d = 1'b1;
          cnt_d = CW'(N);
        end else begin
          err_d = 1'b0;
          cnt_d = '0;
          len_d = bitlen;
          rem_d = RW'(1) << bitlen;
        end
      end
      DIV: begin
        rem_d = RW'(rem_sub << 1);
        quo_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N)) begin
          state_d        = DONE;
          out_valid_d    = 1'b1;
          dividend_out_d = dvd_q;
          if (err_q) begin
            div_inverse_d = '0;
            div_shift_d   = '0;
            div_err_d     = 1'b1;
          end else begin
            div_inverse_d = WIDTH_INVERSE'(quo_next + RW'(rem_sub != '0));
            div_shift_d   = WIDTH_SHIFT'(N) + WIDTH_SHIFT'(len_q);
            div_err_d     = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dvd_q        <= '0;
      dsr_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      dividend_out <= '0;
      div_inverse  <= '0;
      div_shift    <= '0;
      div_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dvd_q        <= dvd_d;
      dsr_q        <= dsr_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      in_ready     <= in_ready_d;
      out_valid    <= out_valid_d;
      dividend_out <= dividend_out_d;
      div_inverse  <= div_inverse_d;
      div_shift    <= div_shift_d;
      div_err      <= div_err_d;
    end
  end

endmodule

// File: tb/tb_div_inverse_gen.sv
// Bench for div_inverse_gen: scoreboard of reference reciprocals, latency,
// stall, zero-divisor, mid-flight reset and randomized quotient checks.
module tb_div_inverse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dividend_out;
  logic [16:0] div_inverse;
  logic [5:0]  div_shift;
  logic        div_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] dvd;
    logic [16:0] m;
    logic [5:0]  s;
    logic        err;
  } exp_t;

  exp_t sb[$];

  div_inverse_gen #(
    .DIVIDEND_WIDTH(16),
    .WIDTH_INVERSE (17),
    .WIDTH_SHIFT   (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dividend_out(dividend_out),
    .div_inverse (div_inverse),
    .div_shift   (div_shift),
    .div_err     (div_err)
  );

  always #5 clk = ~clk;

  // Reference: smallest l with 2^l >= d, then ceiling division in 64 bits
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    longint unsigned p;
    int l;
    e.dvd = a;
    if (d == 16'd0) begin
      e.m = '0; e.s = '0; e.err = 1'b1;
    end else begin
      l = 0;
      while ((64'd1 << l) < 64'(d)) l++;
      p = 64'd1 << (16 + l);
      e.m   = 17'((p + 64'(d) - 64'd1) / 64'(d));
      e.s   = 6'(16 + l);
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] d);
    int w;
    w = 0;
    sb.push_back(model(a, d));
    dividend = a; divisor = d; in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns edges from accept until out_valid, or -1 if it never came
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_err !== 1'b0 ||
        div_inverse !== 17'd0 || div_shift !== 6'd0 || dividend_out !== 16'd0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b err=%b m=%h s=%0d dvd=%0d, want 1 0 0 0 0 0",
               in_ready, out_valid, div_err, div_inverse, div_shift, dividend_out);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] ta [4];
    logic [15:0] td [4];
    logic [16:0] tm [4];
    logic [5:0]  ts [4];
    exp_t e;
    int lat;
    ta = '{16'd100, 16'd777, 16'd40000, 16'd65535};
    td = '{16'd3, 16'd1, 16'd1024, 16'd65535};
    tm = '{17'h15556, 17'h10000, 17'h10000, 17'h10002};
    ts = '{6'd18, 6'd16, 6'd26, 6'd32};
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], td[i]);
      wait_out(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 18) begin n_fail++; $display("FAIL basic_latency d=%0d: got %0d, want 18", td[i], lat); end
      n_checks++;
      if (div_inverse !== tm[i] || div_inverse !== e.m) begin
        n_fail++; $display("FAIL basic_inverse d=%0d: got %h, want %h", td[i], div_inverse, tm[i]);
      end
      n_checks++;
      if (div_shift !== ts[i] || div_shift !== e.s) begin
        n_fail++; $display("FAIL basic_shift d=%0d: got %0d, want %0d", td[i], div_shift, ts[i]);
      end
      n_checks++;
      if (dividend_out !== e.dvd || div_err !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL basic_misc d=%0d: dvd=%0d err=%b in_ready=%b, want %0d 0 0",
                           td[i], dividend_out, div_err, in_ready, e.dvd);
      end
      consume();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL basic_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_zero();
    exp_t e;
    int lat;
    issue(16'd42, 16'd0);
    wait_out(lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL zero_latency: got %0d, want 2", lat); end
    n_checks++;
    if (div_err !== e.err || div_inverse !== 17'd0 || div_shift !== 6'd0 || dividend_out !== e.dvd) begin
      n_fail++; $display("FAIL zero_outputs: err=%b m=%h s=%0d dvd=%0d, want 1 0 0 %0d",
                         div_err, div_inverse, div_shift, dividend_out, e.dvd);
    end
    consume();
  endtask

  task automatic test_stall();
    exp_t e;
    int lat;
    issue(16'd1234, 16'd5);
    wait_out(lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 18 || div_inverse !== 17'd104858) begin
      n_fail++; $display("FAIL stall_first: lat=%0d m=%h, want 18 %h", lat, div_inverse, 17'd104858);
    end
    in_valid = 1'b1; dividend = 16'd999; divisor = 16'd77;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || div_inverse !== e.m ||
          div_shift !== e.s || dividend_out !== e.dvd || div_err !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold c=%0d: v=%b rdy=%b m=%h s=%0d dvd=%0d, want 1 0 %h %0d %0d",
                           c, out_valid, in_ready, div_inverse, div_shift, dividend_out, e.m, e.s, e.dvd);
      end
    end
    in_valid = 1'b0;
    consume();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_not_latched: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat;
    issue(16'd4321, 16'd9);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(16'd555, 16'd7);
    wait_out(lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 18 || div_inverse !== 17'h12493 || div_inverse !== e.m || div_shift !== 6'd19) begin
      n_fail++; $display("FAIL reset_recover: lat=%0d m=%h s=%0d, want 18 12493 19", lat, div_inverse, div_shift);
    end
    consume();
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    logic [15:0] a, d;
    longint unsigned q;
    for (int i = 0; i < 1500; i++) begin
      a = 16'($urandom_range(0, 65535));
      d = (i % 4 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(1, 65535));
      issue(a, d);
      wait_out(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 18 || div_inverse !== e.m || div_shift !== e.s || dividend_out !== e.dvd || div_err !== 1'b0) begin
        n_fail++; $display("FAIL random_fields a=%0d d=%0d: lat=%0d m=%h s=%0d dvd=%0d, want 18 %h %0d %0d",
                           a, d, lat, div_inverse, div_shift, dividend_out, e.m, e.s, e.dvd);
      end
      q = (64'(dividend_out) * 64'(div_inverse)) >> div_shift;
      n_checks++;
      if (q !== 64'(a / d)) begin
        n_fail++; $display("FAIL random_quotient a=%0d d=%0d: got %0d, want %0d", a, d, q, a / d);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
